// File: rtl/trap_controller_pkg.sv
// Shared constants for the user-mode trap sequencer: FSM states, interrupt
// cause codes, ustatus/uip bit positions, utvec modes and ustatus update helpers.
package trap_controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TRAP  = 2'd1,
      ST_REDIR = 2'd2,
      ST_RET   = 2'd3
   } trap_state_e;

   localparam logic [4:0] IRQ_SW    = 5'd0;
   localparam logic [4:0] IRQ_TIMER = 5'd4;
   localparam logic [4:0] IRQ_EXT   = 5'd8;

   localparam int unsigned USTATUS_UIE  = 0;
   localparam int unsigned USTATUS_UPIE = 4;

   localparam int unsigned UIP_SW    = 0;
   localparam int unsigned UIP_TIMER = 4;
   localparam int unsigned UIP_EXT   = 8;

   localparam logic [1:0] UTVEC_DIRECT   = 2'b00;
   localparam logic [1:0] UTVEC_VECTORED = 2'b01;

   // Trap entry: stash UIE into UPIE and disable further interrupts.
   function automatic logic [31:0] trap_entry_ustatus(input logic [31:0] us);
      logic [31:0] r;
      r               = us;
      r[USTATUS_UPIE] = us[USTATUS_UIE];
      r[USTATUS_UIE]  = 1'b0;
      return r;
   endfunction

   function automatic logic [31:0] trap_return_ustatus(input logic [31:0] us);
      logic [31:0] r;
      r               = us;
      r[USTATUS_UIE]  = us[USTATUS_UPIE];
      r[USTATUS_UPIE] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/trap_controller_csr_counters.sv
// Free-running cycle, time and instret counters feeding the read-only CSRs.
// time advances once every TIME_DIV core clocks via a local prescaler.
module trap_controller_csr_counters
   import trap_controller_pkg::*;
#(
   parameter int unsigned TIME_DIV = 50
) (
   input  logic        core_clock,
   input  logic        reset,
   input  logic        instr_retire,
   input  logic        exc_valid,
   output logic [63:0] cycles_counter,
   output logic [63:0] time_counter,
   output logic [63:0] instret_counter
);

   localparam int unsigned PRESC_W = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TIME_DIV - 1);

   logic [PRESC_W-1:0] presc_r;
   logic [63:0]        cycle_r;
   logic [63:0]        time_r;
   logic [63:0]        instret_r;

   // Counter and prescaler state; counters wrap naturally at 2^64.
   always_ff @(posedge core_clock) begin
      if (!reset) begin
         presc_r   <= '0;
         cycle_r   <= 64'd0;
         time_r    <= 64'd0;
         instret_r <= 64'd0;
      end else begin
         cycle_r <= cycle_r + 64'd1;
         if (presc_r == PRESC_MAX) begin
            presc_r <= '0;
            time_r  <= time_r + 64'd1;
         end else begin
            presc_r <= presc_r + PRESC_W'(1);
         end
         if (instr_retire && !exc_valid) begin
            instret_r <= instret_r + 64'd1;
         end
      end
   end

   assign cycles_counter  = cycle_r;
   assign time_counter    = time_r;
   assign instret_counter = instret_r;

endmodule

// File: rtl/trap_controller.sv
// User-mode trap sequencer: arbitrates exceptions, interrupts and uret, drives the
// CSR file trap-write and ustatus ports, and redirects fetch to the handler or uepc.
module trap_controller
   import trap_controller_pkg::*;
#(
   parameter int unsigned TIME_DIV    = 50,
   parameter bit          VECTORED_EN = 1'b1
) (
   input  logic        core_clock,
   input  logic        reset,
   input  logic        instr_retire,
   input  logic [31:0] instr_pc,
   input  logic [31:0] instr_next_pc,
   input  logic        exc_valid,
   input  logic [4:0]  exc_cause,
   input  logic [31:0] exc_tval,
   input  logic        uret,
   input  logic        ext_irq,
   input  logic        timer_irq,
   input  logic        sw_irq,
   input  logic [31:0] csr_ustatus,
   input  logic [31:0] csr_utvec,
   input  logic [31:0] csr_uepc,
   input  logic [31:0] csr_uie,
   output logic        trap_write,
   output logic [31:0] trap_uepc,
   output logic [31:0] trap_ucause,
   output logic [31:0] trap_utval,
   output logic        ustatus_we,
   output logic [31:0] ustatus_wdata,
   output logic [31:0] irq_pending,
   output logic        pc_redirect,
   output logic [31:0] redirect_pc,
   output logic        stall,
   output logic [63:0] cycles_counter,
   output logic [63:0] time_counter,
   output logic [63:0] instret_counter
);

   trap_state_e state_r, next_state_s;

   logic        trap_write_r,    trap_write_nxt_s;
   logic [31:0] trap_uepc_r,     trap_uepc_nxt_s;
   logic [31:0] trap_ucause_r,   trap_ucause_nxt_s;
   logic [31:0] trap_utval_r,    trap_utval_nxt_s;
   logic        ustatus_we_r,    ustatus_we_nxt_s;
   logic [31:0] ustatus_wdata_r, ustatus_wdata_nxt_s;
   logic        pc_redirect_r,   pc_redirect_nxt_s;
   logic [31:0] redirect_pc_r,   redirect_pc_nxt_s;
   logic        stall_r;
   logic [31:0] irq_pending_r;

   logic [31:0] pend_en_s;
   logic        intr_ok_s;
   logic [4:0]  irq_code_s;
   logic [31:0] vec_base_s;
   logic [31:0] vec_pc_s;

   // Enabled-interrupt selection: ext beats sw beats timer.
   always_comb begin
      pend_en_s = irq_pending_r & csr_uie;
      intr_ok_s = csr_ustatus[USTATUS_UIE] & (|pend_en_s);
      if (pend_en_s[UIP_EXT]) begin
         irq_code_s = IRQ_EXT;
      end else if (pend_en_s[UIP_SW]) begin
         irq_code_s = IRQ_SW;
      end else begin
         irq_code_s = IRQ_TIMER;
      end
   end

   // Handler target; the latched ucause tells whether the trap was an interrupt.
   always_comb begin
      vec_base_s = {csr_utvec[31:2], 2'b00};
      if (VECTORED_EN && (csr_utvec[1:0] == UTVEC_VECTORED) && trap_ucause_r[31]) begin
         vec_pc_s = vec_base_s + {25'd0, trap_ucause_r[4:0], 2'b00};
      end else begin
         vec_pc_s = vec_base_s;
      end
   end

   // Next state plus the values the output registers load at the coming edge.
   always_comb begin
      next_state_s        = state_r;
      trap_write_nxt_s    = 1'b0;
      ustatus_we_nxt_s    = 1'b0;
      pc_redirect_nxt_s   = 1'b0;
      trap_uepc_nxt_s     = trap_uepc_r;
      trap_ucause_nxt_s   = trap_ucause_r;
      trap_utval_nxt_s    = trap_utval_r;
      ustatus_wdata_nxt_s = ustatus_wdata_r;
      redirect_pc_nxt_s   = redirect_pc_r;
      case (state_r)
         ST_IDLE: begin
            if (exc_valid) begin
               next_state_s        = ST_TRAP;
               trap_write_nxt_s    = 1'b1;
               trap_uepc_nxt_s     = instr_pc;
               trap_ucause_nxt_s   = {27'd0, exc_cause};
               trap_utval_nxt_s    = exc_tval;
               ustatus_we_nxt_s    = 1'b1;
               ustatus_wdata_nxt_s = trap_entry_ustatus(csr_ustatus);
            end else if (instr_retire && intr_ok_s) begin
               next_state_s        = ST_TRAP;
               trap_write_nxt_s    = 1'b1;
               trap_uepc_nxt_s     = instr_next_pc;
               trap_ucause_nxt_s   = {1'b1, 26'd0, irq_code_s};
               trap_utval_nxt_s    = 32'd0;
               ustatus_we_nxt_s    = 1'b1;
               ustatus_wdata_nxt_s = trap_entry_ustatus(csr_ustatus);
            end else if (uret) begin
               next_state_s        = ST_RET;
               pc_redirect_nxt_s   = 1'b1;
               redirect_pc_nxt_s   = csr_uepc;
               ustatus_we_nxt_s    = 1'b1;
               ustatus_wdata_nxt_s = trap_return_ustatus(csr_ustatus);
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_TRAP: begin
            next_state_s      = ST_REDIR;
            pc_redirect_nxt_s = 1'b1;
            redirect_pc_nxt_s = vec_pc_s;
         end
         ST_REDIR: next_state_s = ST_IDLE;
         ST_RET:   next_state_s = ST_IDLE;
         default:  next_state_s = ST_IDLE;
      endcase
   end

   // State and output registers; outputs reflect the state entered at this edge.
   always_ff @(posedge core_clock) begin
      if (!reset) begin
         state_r         <= ST_IDLE;
         trap_write_r    <= 1'b0;
         trap_uepc_r     <= 32'd0;
         trap_ucause_r   <= 32'd0;
         trap_utval_r    <= 32'd0;
         ustatus_we_r    <= 1'b0;
         ustatus_wdata_r <= 32'd0;
         pc_redirect_r   <= 1'b0;
         redirect_pc_r   <= 32'd0;
         stall_r         <= 1'b0;
         irq_pending_r   <= 32'd0;
      end else begin
         state_r         <= next_state_s;
         trap_write_r    <= trap_write_nxt_s;
         trap_uepc_r     <= trap_uepc_nxt_s;
         trap_ucause_r   <= trap_ucause_nxt_s;
         trap_utval_r    <= trap_utval_nxt_s;
         ustatus_we_r    <= ustatus_we_nxt_s;
         ustatus_wdata_r <= ustatus_wdata_nxt_s;
         pc_redirect_r   <= pc_redirect_nxt_s;
         redirect_pc_r   <= redirect_pc_nxt_s;
         stall_r         <= (next_state_s != ST_IDLE);
         irq_pending_r   <= {23'd0, ext_irq, 3'd0, timer_irq, 3'd0, sw_irq};
      end
   end

   assign trap_write    = trap_write_r;
   assign trap_uepc     = trap_uepc_r;
   assign trap_ucause   = trap_ucause_r;
   assign trap_utval    = trap_utval_r;
   assign ustatus_we    = ustatus_we_r;
   assign ustatus_wdata = ustatus_wdata_r;
   assign pc_redirect   = pc_redirect_r;
   assign redirect_pc   = redirect_pc_r;
   assign stall         = stall_r;
   assign irq_pending   = irq_pending_r;

   trap_controller_csr_counters #(
      .TIME_DIV (TIME_DIV)
   ) u_counters (
      .core_clock      (core_clock),
      .reset           (reset),
      .instr_retire    (instr_retire),
      .exc_valid       (exc_valid),
      .cycles_counter  (cycles_counter),
      .time_counter    (time_counter),
      .instret_counter (instret_counter)
   );

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against an event-level model.
module tb_trap_controller;

   localparam int unsigned TDIV = 50;

   logic        core_clock = 1'b0;
   logic        reset;
   logic        instr_retire;
   logic [31:0] instr_pc;
   logic [31:0] instr_next_pc;
   logic        exc_valid;
   logic [4:0]  exc_cause;
   logic [31:0] exc_tval;
   logic        uret;
   logic        ext_irq;
   logic        timer_irq;
   logic        sw_irq;
   logic [31:0] csr_ustatus;
   logic [31:0] csr_utvec;
   logic [31:0] csr_uepc;
   logic [31:0] csr_uie;
   logic        trap_write;
   logic [31:0] trap_uepc;
   logic [31:0] trap_ucause;
   logic [31:0] trap_utval;
   logic        ustatus_we;
   logic [31:0] ustatus_wdata;
   logic [31:0] irq_pending;
   logic        pc_redirect;
   logic [31:0] redirect_pc;
   logic        stall;
   logic [63:0] cycles_counter;
   logic [63:0] time_counter;
   logic [63:0] instret_counter;

   trap_controller #(.TIME_DIV(TDIV), .VECTORED_EN(1'b1)) dut (
      .core_clock(core_clock), .reset(reset),
      .instr_retire(instr_retire), .instr_pc(instr_pc), .instr_next_pc(instr_next_pc),
      .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval), .uret(uret),
      .ext_irq(ext_irq), .timer_irq(timer_irq), .sw_irq(sw_irq),
      .csr_ustatus(csr_ustatus), .csr_utvec(csr_utvec), .csr_uepc(csr_uepc), .csr_uie(csr_uie),
      .trap_write(trap_write), .trap_uepc(trap_uepc), .trap_ucause(trap_ucause),
      .trap_utval(trap_utval), .ustatus_we(ustatus_we), .ustatus_wdata(ustatus_wdata),
      .irq_pending(irq_pending), .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
      .stall(stall), .cycles_counter(cycles_counter), .time_counter(time_counter),
      .instret_counter(instret_counter)
   );

   always #5 core_clock = ~core_clock;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: event-level view of what the CSR file and fetch must see.
   bit          m_valid = 1'b0;
   logic [63:0] m_cycle, m_instret;
   logic        m_trap_write, m_ustatus_we, m_pc_redirect, m_stall;
   logic [31:0] m_uepc, m_ucause, m_utval, m_wdata, m_rpc, m_irq;
   int          m_busy = 0;
   bit          m_redir_due = 1'b0;
   bit          m_int = 1'b0;
   int          m_code = 0;

   task automatic model_step();
      logic [31:0] en;
      logic [31:0] tgt;
      if (!reset) begin
         m_valid = 1'b1;
         m_cycle = 64'd0; m_instret = 64'd0;
         m_trap_write = 1'b0; m_ustatus_we = 1'b0; m_pc_redirect = 1'b0; m_stall = 1'b0;
         m_uepc = 32'd0; m_ucause = 32'd0; m_utval = 32'd0; m_wdata = 32'd0;
         m_rpc = 32'd0; m_irq = 32'd0;
         m_busy = 0; m_redir_due = 1'b0;
      end else begin
         m_cycle = m_cycle + 64'd1;
         if (instr_retire && !exc_valid) m_instret = m_instret + 64'd1;
         m_trap_write = 1'b0; m_ustatus_we = 1'b0; m_pc_redirect = 1'b0;
         if (m_busy == 0) begin
            en = m_irq & csr_uie;
            if (exc_valid) begin
               m_trap_write = 1'b1; m_uepc = instr_pc; m_ucause = 32'(exc_cause);
               m_utval = exc_tval; m_int = 1'b0;
            end else if (instr_retire && csr_ustatus[0] && en != 32'd0) begin
               m_code = en[8] ? 8 : (en[0] ? 0 : 4);
               m_trap_write = 1'b1; m_uepc = instr_next_pc;
               m_ucause = 32'h8000_0000 + 32'(m_code); m_utval = 32'd0; m_int = 1'b1;
            end
            if (m_trap_write) begin
               m_ustatus_we = 1'b1;
               m_wdata = (csr_ustatus & ~32'h11) | (csr_ustatus[0] ? 32'h10 : 32'h0);
               m_busy = 2; m_redir_due = 1'b1; m_stall = 1'b1;
            end else if (uret) begin
               m_pc_redirect = 1'b1; m_rpc = csr_uepc; m_ustatus_we = 1'b1;
               m_wdata = (csr_ustatus & ~32'h1) | 32'h10 | (csr_ustatus[4] ? 32'h1 : 32'h0);
               m_busy = 1; m_stall = 1'b1;
            end else begin
               m_stall = 1'b0;
            end
         end else begin
            m_busy = m_busy - 1;
            if (m_redir_due) begin
               tgt = csr_utvec & 32'hFFFF_FFFC;
               if (m_int && csr_utvec[1:0] == 2'b01) tgt = tgt + 32'(4 * m_code);
               m_pc_redirect = 1'b1; m_rpc = tgt; m_redir_due = 1'b0;
            end
            m_stall = (m_busy != 0);
         end
         m_irq = (ext_irq ? 32'h100 : 32'h0) | (timer_irq ? 32'h10 : 32'h0) | (sw_irq ? 32'h1 : 32'h0);
      end
   endtask

   initial forever begin
      @(posedge core_clock);
      model_step();
   end

   // Every-cycle comparison of the DUT against the model, away from the active edge.
   initial forever begin
      @(negedge core_clock);
      if (m_valid) begin
         chk("trap_write", 64'(trap_write), 64'(m_trap_write));
         chk("trap_uepc", 64'(trap_uepc), 64'(m_uepc));
         chk("trap_ucause", 64'(trap_ucause), 64'(m_ucause));
         chk("trap_utval", 64'(trap_utval), 64'(m_utval));
         chk("ustatus_we", 64'(ustatus_we), 64'(m_ustatus_we));
         chk("ustatus_wdata", 64'(ustatus_wdata), 64'(m_wdata));
         chk("irq_pending", 64'(irq_pending), 64'(m_irq));
         chk("pc_redirect", 64'(pc_redirect), 64'(m_pc_redirect));
         chk("redirect_pc", 64'(redirect_pc), 64'(m_rpc));
         chk("stall", 64'(stall), 64'(m_stall));
         chk("cycles", cycles_counter, m_cycle);
         chk("time", time_counter, m_cycle / 64'(TDIV));
         chk("instret", instret_counter, m_instret);
      end
   end

   task automatic tick();
      @(posedge core_clock);
      @(negedge core_clock);
   endtask

   task automatic clear_events();
      instr_retire = 1'b0; exc_valid = 1'b0; uret = 1'b0;
      ext_irq = 1'b0; timer_irq = 1'b0; sw_irq = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      clear_events();
      instr_pc = 32'd0; instr_next_pc = 32'd0; exc_cause = 5'd0; exc_tval = 32'd0;
      csr_ustatus = 32'd0; csr_utvec = 32'd0; csr_uepc = 32'd0; csr_uie = 32'd0;
      repeat (3) tick();
      chk("rst_cycles", cycles_counter, 64'd0);
      chk("rst_trap_write", 64'(trap_write), 64'd0);
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_redirect_pc", 64'(redirect_pc), 64'd0);

      // Counters: 1000 cycles after reset release
      reset = 1'b1;
      repeat (1000) tick();
      chk("cnt_cycles_1000", cycles_counter, 64'd1000);
      chk("cnt_time_20", time_counter, 64'd20);
      chk("model_time_20", m_cycle / 64'(TDIV), 64'd20);
      chk("cnt_instret_0", instret_counter, 64'd0);

      // Synchronous exception
      csr_utvec = 32'h1000;
      exc_valid = 1'b1; exc_cause = 5'd2; instr_pc = 32'h400; exc_tval = 32'hDEAD_BEEF;
      tick();
      chk("exc_trap_write", 64'(trap_write), 64'd1);
      chk("exc_uepc", 64'(trap_uepc), 64'h400);
      chk("exc_ucause", 64'(trap_ucause), 64'd2);
      chk("exc_utval", 64'(trap_utval), 64'hDEAD_BEEF);
      chk("exc_stall1", 64'(stall), 64'd1);
      chk("exc_no_early_redirect", 64'(pc_redirect), 64'd0);
      clear_events();
      tick();
      chk("exc_redirect", 64'(pc_redirect), 64'd1);
      chk("exc_redirect_pc", 64'(redirect_pc), 64'h1000);
      chk("exc_stall2", 64'(stall), 64'd1);
      tick();
      chk("exc_stall_done", 64'(stall), 64'd0);

      // Vectored external interrupt taken on a retiring instruction
      csr_ustatus = 32'h1; csr_uie = 32'h100; csr_utvec = 32'h2001; ext_irq = 1'b1;
      tick();
      chk("irq_pending_ext", 64'(irq_pending), 64'h100);
      instr_retire = 1'b1; instr_pc = 32'h800; instr_next_pc = 32'h804;
      tick();
      chk("irq_trap_write", 64'(trap_write), 64'd1);
      chk("irq_ucause", 64'(trap_ucause), 64'h8000_0008);
      chk("model_irq_ucause", 64'(m_ucause), 64'h8000_0008);
      chk("irq_uepc", 64'(trap_uepc), 64'h804);
      chk("irq_utval", 64'(trap_utval), 64'd0);
      chk("irq_wdata", 64'(ustatus_wdata), 64'h10);
      clear_events();
      tick();
      chk("irq_redirect_pc", 64'(redirect_pc), 64'h2020);
      tick();

      // Masking: UIE clear with every interrupt pending
      csr_ustatus = 32'h0; csr_uie = 32'h111;
      ext_irq = 1'b1; timer_irq = 1'b1; sw_irq = 1'b1; instr_retire = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("mask_no_trap", 64'(trap_write), 64'd0);
         chk("mask_no_stall", 64'(stall), 64'd0);
      end

      // Priority: exception beats interrupt and uret
      csr_ustatus = 32'h1; exc_valid = 1'b1; uret = 1'b1;
      exc_cause = 5'd5; instr_pc = 32'h900; exc_tval = 32'h1234;
      tick();
      chk("prio_ucause", 64'(trap_ucause), 64'd5);
      chk("prio_uepc", 64'(trap_uepc), 64'h900);
      chk("prio_no_uret_redirect", 64'(pc_redirect), 64'd0);
      clear_events();
      tick();
      chk("prio_redirect_pc", 64'(redirect_pc), 64'h2000);
      tick();

      // uret
      csr_uepc = 32'h804; csr_ustatus = 32'h10; uret = 1'b1;
      tick();
      chk("uret_redirect", 64'(pc_redirect), 64'd1);
      chk("uret_redirect_pc", 64'(redirect_pc), 64'h804);
      chk("uret_wdata", 64'(ustatus_wdata), 64'h11);
      chk("uret_ustatus_we", 64'(ustatus_we), 64'd1);
      clear_events();
      tick();
      chk("uret_done", 64'(pc_redirect), 64'd0);

      // Reset asserted while in REDIR
      exc_valid = 1'b1; exc_cause = 5'd1;
      tick();
      clear_events();
      tick();
      chk("rstredir_in_redir", 64'(pc_redirect), 64'd1);
      reset = 1'b0;
      tick();
      chk("rstredir_redirect", 64'(pc_redirect), 64'd0);
      chk("rstredir_stall", 64'(stall), 64'd0);
      chk("rstredir_cycles", cycles_counter, 64'd0);
      chk("rstredir_time", time_counter, 64'd0);
      chk("rstredir_instret", instret_counter, 64'd0);
      reset = 1'b1;

      // Randomized traffic; CSRs only move while the sequencer is idle
      for (int i = 0; i < 4000; i++) begin
         reset        = ($urandom_range(0, 299) != 0);
         exc_valid    = ($urandom_range(0, 7) == 0);
         uret         = ($urandom_range(0, 7) == 0);
         instr_retire = ($urandom_range(0, 1) == 1);
         ext_irq      = ($urandom_range(0, 3) == 0);
         timer_irq    = ($urandom_range(0, 3) == 0);
         sw_irq       = ($urandom_range(0, 3) == 0);
         exc_cause    = 5'($urandom_range(0, 31));
         exc_tval     = $urandom;
         instr_pc     = $urandom & 32'hFFFF_FFFC;
         instr_next_pc = instr_pc + 32'd4;
         if (m_busy == 0 && $urandom_range(0, 3) == 0) begin
            csr_ustatus = $urandom & 32'h0000_0011;
            csr_uie     = $urandom & 32'h0000_0111;
            csr_utvec   = $urandom & 32'h0000_FFFF;
            csr_uepc    = $urandom & 32'hFFFF_FFFC;
         end
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
